// File: rtl/t04_control_sequencer.sv
// Multicycle control sequencer for the team 04 RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// handshaking with the instruction and data memories over req/ack pairs.
// A bounded wait counter turns a missing ack into a sticky fault and HALT.
module t04_control_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             i_ack,
    input  logic             d_ack,
    output logic             i_req,
    output logic             d_read,
    output logic             d_write,
    output logic             ir_load,
    output logic             alu_src,
    output logic             reg_write,
    output logic             pc_en,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Wait counter only needs to hold 0..TIMEOUT-1; the last value is the
    // final cycle in which an ack is still accepted.
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // SYSTEM (1110011) is deliberately absent so it falls through to HALT.
    function automatic logic is_legal(input logic [6:0] op);
        unique case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] wb_sel_of(input logic [6:0] op);
        unique case (op)
            OP_LOAD:         wb_sel_of = WB_MEM;
            OP_JAL, OP_JALR: wb_sel_of = WB_PC4;
            OP_LUI:          wb_sel_of = WB_IMM;
            default:         wb_sel_of = WB_ALU;
        endcase
    endfunction

    logic is_load, is_store, is_branch, alu_imm;
    logic [1:0] wb_sel_op;

    // Instruction class decoded from the latched opcode.
    always_comb begin
        is_load   = (op_q == OP_LOAD);
        is_store  = (op_q == OP_STORE);
        is_branch = (op_q == OP_BRANCH);
        alu_imm   = !((op_q == OP_R) || is_branch);
        wb_sel_op = wb_sel_of(op_q);
    end

    // Next-state logic: sequencing, opcode latch, wait counter and fault.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        fault_d = fault_q;

        unique case (state_q)
            StIdle: begin
                if (en) state_d = StFetch;
            end
            StFetch: begin
                if (i_ack) begin
                    state_d = StDecode;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDecode: begin
                op_d    = opcode;
                state_d = is_legal(opcode) ? StExec : StHalt;
            end
            StExec: begin
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    state_d = en ? StFetch : StIdle;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (d_ack) begin
                    if (is_load) state_d = StWb;
                    else         state_d = en ? StFetch : StIdle;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                state_d = en ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any state change starts a fresh wait window; this covers every
        // entry into FETCH and MEM, the only states that consult it.
        if (state_d != state_q) wait_d = '0;
    end

    // Moore outputs from state and latched opcode; ir_load and the store
    // retire strobe additionally qualify on their ack.
    always_comb begin
        i_req     = 1'b0;
        ir_load   = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        pc_en     = 1'b0;
        wb_sel    = WB_ALU;

        unique case (state_q)
            StFetch: begin
                i_req   = 1'b1;
                ir_load = i_ack;
            end
            StExec: begin
                alu_src = alu_imm;
                pc_en   = is_branch;
            end
            StMem: begin
                alu_src = alu_imm;
                d_read  = is_load;
                d_write = is_store;
                pc_en   = is_store && d_ack;
            end
            StWb: begin
                alu_src   = alu_imm;
                reg_write = 1'b1;
                pc_en     = 1'b1;
                wb_sel    = wb_sel_op;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = pc_en ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule
